// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
//
// Shared definitions for the elevator request front end and the elevator
// controller that consumes its request vectors.
//
//   NUM_FLOORS    default number of floors (width of every request vector)
//   FLOOR_W       default width of a floor index, clog2(NUM_FLOORS)
//   DWELL_CYCLES  default number of cycles the door stays open (1..255)
//   DWELL_W       width of the door dwell counter
//   door_state_t  door FSM states
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_FLOORS   = 4;
    localparam int FLOOR_W      = 2;
    localparam int DWELL_CYCLES = 8;

    // Eight bits covers the whole legal dwell range of 1..255 cycles.
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } door_state_t;

endpackage : elevator_pkg

// File: rtl/elevator_request_latch_if.sv
// -----------------------------------------------------------------------------
// elevator_request_latch_if
//
// Bundle between the button/door front end and whatever drives it (the car
// hardware plus the controller).
//
//   raw_buttons_in   in-car buttons, asynchronous level while pressed
//   raw_buttons_out  hall buttons, asynchronous level while pressed
//   current_floor    floor the car is at
//   car_stopped      high while the controller's motor is idle
//   buttons_in       latched in-car requests
//   buttons_out      latched hall requests
//   door_open        door-open command
//   door_busy        door FSM not idle; motor must stay off
//   pending          any request latched
//
// Modports:
//   master  the environment: drives buttons, floor and car_stopped
//   slave   the request latch: drives requests and door status
// -----------------------------------------------------------------------------
interface elevator_request_latch_if #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
);

    logic [NUM_FLOORS-1:0] raw_buttons_in;
    logic [NUM_FLOORS-1:0] raw_buttons_out;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_stopped;

    logic [NUM_FLOORS-1:0] buttons_in;
    logic [NUM_FLOORS-1:0] buttons_out;
    logic                  door_open;
    logic                  door_busy;
    logic                  pending;

    modport master (
        output raw_buttons_in,
        output raw_buttons_out,
        output current_floor,
        output car_stopped,
        input  buttons_in,
        input  buttons_out,
        input  door_open,
        input  door_busy,
        input  pending
    );

    modport slave (
        input  raw_buttons_in,
        input  raw_buttons_out,
        input  current_floor,
        input  car_stopped,
        output buttons_in,
        output buttons_out,
        output door_open,
        output door_busy,
        output pending
    );

endinterface : elevator_request_latch_if

// File: rtl/elevator_request_latch_sync_edge.sv
// -----------------------------------------------------------------------------
// button_sync_edge
//
// One push-button bit: two-flop synchroniser followed by a rising-edge
// detector. All flops clear on reset, so a button held through reset is seen
// as a fresh press once reset is released.
//
//   clk    system clock
//   reset  synchronous, active-high
//   raw    asynchronous button level
//   rise   one-cycle pulse on the synchronised 0->1 transition
// -----------------------------------------------------------------------------
module button_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~prev_reg;

endmodule : button_sync_edge

// File: rtl/elevator_request_latch.sv
// -----------------------------------------------------------------------------
// elevator_request_latch
//
// Front end of the elevator controller. Synchronises the raw in-car and hall
// buttons, latches each press into a held request vector, clears the requests
// for a floor when the car stops there, and runs the door dwell FSM.
//
// Parameters:
//   NUM_FLOORS    number of floors / width of the request vectors
//   FLOOR_W       width of current_floor
//   DWELL_CYCLES  cycles the door stays open, 1..255
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    elevator_request_latch_if.slave (buttons in, requests/door out)
//
// Door FSM:
//   IDLE  -> OPEN   car stopped with a request latched at current_floor; both
//                   request bits for that floor clear on the same edge.
//   OPEN  -> CLOSE  after DWELL_CYCLES open cycles; a fresh press at the
//                   current floor restarts the dwell instead of latching.
//   CLOSE -> IDLE   always, after one cycle with the door shut.
// -----------------------------------------------------------------------------
module elevator_request_latch #(
    parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = elevator_pkg::DWELL_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    elevator_request_latch_if.slave  bus
);

    import elevator_pkg::*;

    // Counter value on the last open cycle of a dwell.
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    // Synchronised press pulses.
    logic [NUM_FLOORS-1:0] rise_in;
    logic [NUM_FLOORS-1:0] rise_out;

    // One-hot of current_floor; all zero when the index is out of range,
    // which keeps every request untouched rather than aliasing a floor.
    logic [NUM_FLOORS-1:0] floor_mask;

    // Request state.
    logic [NUM_FLOORS-1:0] req_in_reg;
    logic [NUM_FLOORS-1:0] req_out_reg;
    logic [NUM_FLOORS-1:0] req_in_next;
    logic [NUM_FLOORS-1:0] req_out_next;

    // Door state.
    door_state_t           state_reg;
    logic [DWELL_W-1:0]    dwell_cnt_reg;
    logic                  door_open_reg;
    logic                  door_busy_reg;

    // Decode of the current floor against requests and presses.
    logic                  here_req;
    logic                  here_rise;
    logic                  service;
    logic [NUM_FLOORS-1:0] set_mask;
    logic [NUM_FLOORS-1:0] clear_mask;

    // -------------------------------------------------------------------------
    // Per-floor synchronisers and floor decode
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            button_sync_edge u_sync_in (
                .clk   (clk),
                .reset (reset),
                .raw   (bus.raw_buttons_in[gi]),
                .rise  (rise_in[gi])
            );

            button_sync_edge u_sync_out (
                .clk   (clk),
                .reset (reset),
                .raw   (bus.raw_buttons_out[gi]),
                .rise  (rise_out[gi])
            );

            assign floor_mask[gi] = (bus.current_floor == FLOOR_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Request vector next-state
    // -------------------------------------------------------------------------
    always_comb begin
        here_req   = |((req_in_reg | req_out_reg) & floor_mask);
        here_rise  = |((rise_in | rise_out) & floor_mask);
        service    = (state_reg == IDLE) && bus.car_stopped && here_req;

        // While the door is open at this floor a press there only extends the
        // dwell; it must not leave a stale request behind once the door shuts.
        set_mask   = (state_reg == OPEN) ? ~floor_mask : {NUM_FLOORS{1'b1}};

        // The clear is applied after the set so that a press landing on the
        // edge the door opens is absorbed by that opening.
        clear_mask = service ? floor_mask : {NUM_FLOORS{1'b0}};

        req_in_next  = (req_in_reg  | (rise_in  & set_mask)) & ~clear_mask;
        req_out_next = (req_out_reg | (rise_out & set_mask)) & ~clear_mask;
    end

    // -------------------------------------------------------------------------
    // Request registers and door FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            req_in_reg    <= '0;
            req_out_reg   <= '0;
            state_reg     <= IDLE;
            dwell_cnt_reg <= '0;
            door_open_reg <= 1'b0;
            door_busy_reg <= 1'b0;
        end else begin
            req_in_reg  <= req_in_next;
            req_out_reg <= req_out_next;

            case (state_reg)
                IDLE: begin
                    if (service) begin
                        state_reg     <= OPEN;
                        dwell_cnt_reg <= '0;
                        door_open_reg <= 1'b1;
                        door_busy_reg <= 1'b1;
                    end
                end

                OPEN: begin
                    // car_stopped is deliberately not looked at here: once the
                    // door has opened the dwell always runs to completion.
                    if (here_rise) begin
                        dwell_cnt_reg <= '0;
                    end else if (dwell_cnt_reg == DWELL_LAST) begin
                        state_reg     <= CLOSE;
                        door_open_reg <= 1'b0;
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
                    end
                end

                CLOSE: begin
                    state_reg     <= IDLE;
                    door_busy_reg <= 1'b0;
                end

                default: begin
                    state_reg     <= IDLE;
                    door_open_reg <= 1'b0;
                    door_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.buttons_in  = req_in_reg;
    assign bus.buttons_out = req_out_reg;
    assign bus.door_open   = door_open_reg;
    assign bus.door_busy   = door_busy_reg;
    assign bus.pending     = |(req_in_reg | req_out_reg);

endmodule : elevator_request_latch

// File: tb/tb_elevator_request_latch.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_latch
//
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model tracks requests as sets of floors and the door as a
// countdown of remaining open cycles; outputs are compared against it on
// every falling edge once the first reset edge has been seen.
// -----------------------------------------------------------------------------
module tb_elevator_request_latch;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int DW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    elevator_request_latch_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

    elevator_request_latch #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DWELL_CYCLES (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // -------------------------------------------------------------------------
    // Comparison helper
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    //   raw_hist_*[0..2]: button levels seen at the last three edges (newest
    //   first). A press counts once the level has been seen on two edges and
    //   was absent on the edge before that.
    //   open_left: open cycles remaining; close_pending: the shut-but-busy cycle.
    // -------------------------------------------------------------------------
    logic [NF-1:0] m_in, m_out;
    logic [NF-1:0] raw_hist_in  [3];
    logic [NF-1:0] raw_hist_out [3];
    int            open_left;
    bit            close_pending;
    bit            m_valid = 1'b0;

    always @(posedge clk) begin
        logic [NF-1:0] press_in, press_out, here, old_in, old_out;
        if (reset) begin
            m_in = '0;
            m_out = '0;
            for (int i = 0; i < 3; i++) begin
                raw_hist_in[i]  = '0;
                raw_hist_out[i] = '0;
            end
            open_left = 0;
            close_pending = 1'b0;
            m_valid = 1'b1;
        end else begin
            press_in  = raw_hist_in[1]  & ~raw_hist_in[2];
            press_out = raw_hist_out[1] & ~raw_hist_out[2];
            here      = NF'(1) << bus.current_floor;
            old_in    = m_in;
            old_out   = m_out;
            if (open_left > 0) begin
                m_in  = old_in  | (press_in  & ~here);
                m_out = old_out | (press_out & ~here);
                if (((press_in | press_out) & here) != '0) begin
                    open_left = DW;
                end else begin
                    open_left--;
                    if (open_left == 0) close_pending = 1'b1;
                end
            end else if (close_pending) begin
                m_in  = old_in  | press_in;
                m_out = old_out | press_out;
                close_pending = 1'b0;
            end else begin
                m_in  = old_in  | press_in;
                m_out = old_out | press_out;
                if (bus.car_stopped && (((old_in | old_out) & here) != '0)) begin
                    m_in  = m_in  & ~here;
                    m_out = m_out & ~here;
                    open_left = DW;
                end
            end
            raw_hist_in[2]  = raw_hist_in[1];
            raw_hist_in[1]  = raw_hist_in[0];
            raw_hist_in[0]  = bus.raw_buttons_in;
            raw_hist_out[2] = raw_hist_out[1];
            raw_hist_out[1] = raw_hist_out[0];
            raw_hist_out[0] = bus.raw_buttons_out;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model buttons_in",  32'(bus.buttons_in),  32'(m_in));
            check("model buttons_out", 32'(bus.buttons_out), 32'(m_out));
            check("model door_open",   32'(bus.door_open),   32'(open_left > 0));
            check("model door_busy",   32'(bus.door_busy),   32'((open_left > 0) || close_pending));
            check("model pending",     32'(bus.pending),     32'((m_in | m_out) != '0));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bus.raw_buttons_in  = '0;
        bus.raw_buttons_out = 4'b1111;
        bus.current_floor   = '0;
        bus.car_stopped     = 1'b0;

        // Button held through reset
        tick(3);
        check("reset buttons_in",  32'(bus.buttons_in),  32'h0);
        check("reset buttons_out", 32'(bus.buttons_out), 32'h0);
        check("reset door_open",   32'(bus.door_open),   32'h0);
        check("reset door_busy",   32'(bus.door_busy),   32'h0);
        check("reset pending",     32'(bus.pending),     32'h0);
        reset = 1'b0;
        tick(2);
        check("held press edge2", 32'(bus.buttons_out), 32'h0);
        tick(1);
        check("held press edge3", 32'(bus.buttons_out), 32'hF);
        bus.raw_buttons_out = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Latch and hold
        bus.raw_buttons_out = 4'b1000;
        tick(1);
        bus.raw_buttons_out = '0;
        tick(3);
        check("latch buttons_out", 32'(bus.buttons_out), 32'h8);
        check("latch pending",     32'(bus.pending),     32'h1);
        check("latch door_open",   32'(bus.door_open),   32'h0);
        tick(3);
        check("hold buttons_out",  32'(bus.buttons_out), 32'h8);

        // Arrival clear at floor 3
        bus.current_floor = 2'd3;
        bus.car_stopped   = 1'b1;
        tick(1);
        check("arrive buttons_out", 32'(bus.buttons_out), 32'h0);
        check("arrive door_open",   32'(bus.door_open),   32'h1);
        check("arrive door_busy",   32'(bus.door_busy),   32'h1);
        for (int i = 0; i < DW - 1; i++) begin
            tick(1);
            check("dwell door_open", 32'(bus.door_open), 32'h1);
        end
        tick(1);
        check("close door_open", 32'(bus.door_open), 32'h0);
        check("close door_busy", 32'(bus.door_busy), 32'h1);
        tick(1);
        check("idle door_busy",  32'(bus.door_busy), 32'h0);
        bus.car_stopped = 1'b0;

        // Both vectors, then extend at floor 2
        bus.current_floor   = 2'd0;
        bus.raw_buttons_in  = 4'b0110;
        bus.raw_buttons_out = 4'b0100;
        tick(1);
        bus.raw_buttons_in  = '0;
        bus.raw_buttons_out = '0;
        tick(3);
        check("both buttons_in",  32'(bus.buttons_in),  32'h6);
        check("both buttons_out", 32'(bus.buttons_out), 32'h4);
        bus.current_floor  = 2'd2;
        bus.car_stopped    = 1'b1;
        bus.raw_buttons_in = 4'b0100;   // becomes a rise during open cycle 2
        tick(1);
        bus.raw_buttons_in = '0;
        check("both cleared in",  32'(bus.buttons_in),  32'h2);
        check("both cleared out", 32'(bus.buttons_out), 32'h0);
        check("both door_open",   32'(bus.door_open),   32'h1);
        for (int i = 0; i < 1 + DW; i++) begin
            tick(1);
            check("extend door_open", 32'(bus.door_open), 32'h1);
        end
        tick(1);
        check("extend closed",     32'(bus.door_open),  32'h0);
        check("extend buttons_in", 32'(bus.buttons_in), 32'h2);
        tick(1);
        bus.car_stopped = 1'b0;

        // Reset mid-dwell
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        bus.raw_buttons_in  = 4'b0001;
        bus.raw_buttons_out = 4'b0010;
        tick(1);
        bus.raw_buttons_in  = '0;
        bus.raw_buttons_out = '0;
        tick(3);
        bus.current_floor = 2'd1;
        bus.car_stopped   = 1'b1;
        tick(1);
        check("middwell door_open",  32'(bus.door_open),  32'h1);
        check("middwell buttons_in", 32'(bus.buttons_in), 32'h1);
        reset = 1'b1;
        tick(1);
        check("rst open door_open",  32'(bus.door_open),  32'h0);
        check("rst open door_busy",  32'(bus.door_busy),  32'h0);
        check("rst open buttons_in", 32'(bus.buttons_in), 32'h0);
        reset = 1'b0;
        bus.car_stopped = 1'b0;

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.raw_buttons_in  = NF'($urandom & $urandom);
                bus.raw_buttons_out = NF'($urandom & $urandom);
            end
            if ($urandom_range(0, 7) == 0) bus.current_floor = FW'($urandom_range(0, NF - 1));
            bus.car_stopped = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_elevator_request_latch

// File: doc/elevator_request_latch.md
# elevator_request_latch

- Upstream stage of the `elevator` controller.
- Synchronises raw hall and in-car push-buttons and latches each press into a held request vector, which feeds the controller's `buttons_in` / `buttons_out`.
- Clears a floor's requests when the car stops there, and runs the door-dwell FSM.
- Asserts `door_busy` so the controller holds the motor while the door cycles.

## Interface
- `NUM_FLOORS`, default 4: number of floors; sets the width of every request vector.
- `FLOOR_W`, default 2: width of the floor index, clog2(`NUM_FLOORS`).
- `DWELL_CYCLES`, default 8: clock cycles the door stays open; legal range 1..255.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `raw_buttons_in`  in  `NUM_FLOORS`  in-car buttons; asynchronous, level while pressed.
- `raw_buttons_out`  in  `NUM_FLOORS`  hall buttons; asynchronous, level while pressed.
- `current_floor`  in  `FLOOR_W`  floor the car is at.
- `car_stopped`  in  1  high when the controller's motor is idle.
- `buttons_in`  out  `NUM_FLOORS`  latched in-car requests, to the controller.
- `buttons_out`  out  `NUM_FLOORS`  latched hall requests, to the controller.
- `door_open`  out  1  door-open command.
- `door_busy`  out  1  FSM not in IDLE; controller must keep the motor off.
- `pending`  out  1  OR of all bits of `buttons_in` and `buttons_out`.

## Operation
- Reset values: every output 0, every synchroniser and edge flop 0, FSM in IDLE, dwell counter 0.
- Each raw bit passes through a 2-flop synchroniser and then a rising-edge detector (`rise = sync2 & ~prev`).
- A `rise` on bit i sets request bit i; the bit then holds until cleared. Releasing the button does not clear it. Repeated presses are idempotent.
- Door FSM states:
  - IDLE
    - Go to OPEN if `car_stopped` is high and `buttons_in[current_floor]` or `buttons_out[current_floor]` is set.
    - On that same edge, clear both bits at `current_floor`, load the dwell counter with 0, and set `door_open`=1.
  - OPEN
    - Increment the counter each cycle.
    - When the counter equals `DWELL_CYCLES`-1, go to CLOSE.
    - A `rise` on either button at `current_floor` reloads the counter to 0 (reopen/extend). It does not set the request bit.
  - CLOSE
    - Lasts exactly 1 cycle with `door_open`=0, then go to IDLE.
    - A request at `current_floor` that appears while in CLOSE is serviced from IDLE on the next evaluation.
- `door_busy` = (state != IDLE). It is a registered output.
- Presses at other floors latch normally in every state.
- Simultaneous set and clear of the same bit on one edge: clear wins, because the door is opening at that floor.
- `car_stopped` dropping while in OPEN or CLOSE: ignored. The FSM completes the dwell; holding the motor is the controller's contract.
- In-car and hall requests for the same floor are independent bits; both are cleared together on arrival.
- A button held through reset: the edge flop resets to 0, so the press latches once after reset is released.

## Timing
- Press latency: raw bit high before edge k → request bit visible after edge k+2 (3 edges).
- Service latency:
  - A request bit already set, with `car_stopped`=1 at the matching floor, at edge n → the bit reads 0 and `door_open`=1 after edge n.
  - `door_open` stays high for exactly `DWELL_CYCLES` cycles, with no extend presses.
  - `door_busy` is high for `DWELL_CYCLES`+1 cycles.
- Extend: a `rise` sampled in cycle m of OPEN → the door stays open for `DWELL_CYCLES` cycles counted from edge m.
- Reset taken mid-OPEN: on the next edge the state is IDLE, `door_open`=0, and all requests are 0. Nothing is restored.

## Structure
- Shared package `elevator_pkg`: `NUM_FLOORS`, `FLOOR_W`, the door-state enum (IDLE, OPEN, CLOSE), and the `DWELL_CYCLES` default. The `elevator` controller reuses the same package.
- Sub-module `button_sync_edge`: 1-bit 2-flop synchroniser plus rise detector, with sync reset. It is instantiated 2×`NUM_FLOORS` times.
- The top level contains the request registers, the door FSM, and the dwell counter (8 bits).

## Test plan
All scenarios use `DWELL_CYCLES`=4.
- Reset: drive `raw_buttons_out`=4'b1111 during reset → all outputs 0 during reset. After release, `buttons_out`=4'b1111 after 3 edges.
- Latch and hold: pulse `raw_buttons_out[3]` for 1 cycle with `current_floor`=0 and `car_stopped`=0 → `buttons_out`=4'b1000 and stays set. `pending`=1 and `door_open`=0.
- Arrival clear: `buttons_out`=4'b1000, then set `current_floor`=3 and `car_stopped`=1 → on the next edge `buttons_out`=0 and `door_open`=1 for 4 cycles. Then CLOSE for 1 cycle and `door_busy`=0 after that.
- Both vectors: `buttons_in`=4'b0110 and `buttons_out`=4'b0100, stop at floor 2 → both bit-2s cleared on the same edge. `buttons_in`=4'b0010 remains.
- Extend: during OPEN at floor 2, a press on `raw_buttons_in[2]` in cycle 2 → `door_open` high for 2+4 cycles total, and `buttons_in[2]` stays 0.
- Reset mid-dwell: assert `reset` in OPEN cycle 1 with `buttons_in`=4'b0001 → next edge: `door_open`=0, `door_busy`=0, `buttons_in`=0.
